// File: rtl/fifo_frame_reader_pkg.sv
// Shared definitions for fifo_frame_reader: FSM state encoding, default sync bytes,
// payload index width and the helper that says which states present a byte.
package fifo_frame_pkg;

    localparam int PIDX_W = 12;
    localparam int ST_W   = 3;

    localparam logic [7:0] SYNC0_DEF = 8'hA5;
    localparam logic [7:0] SYNC1_DEF = 8'h5A;

    typedef logic [ST_W-1:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SYNC0   = 3'd1;
    localparam state_t ST_SYNC1   = 3'd2;
    localparam state_t ST_SEQ     = 3'd3;
    localparam state_t ST_FETCH   = 3'd4;
    localparam state_t ST_CAPT    = 3'd5;
    localparam state_t ST_PAYLOAD = 3'd6;
    localparam state_t ST_CSUM    = 3'd7;

    // States in which tx_data carries a byte for the transmitter.
    function automatic logic is_tx_state(input state_t s);
        return (s == ST_SYNC0) || (s == ST_SYNC1) || (s == ST_SEQ) ||
               (s == ST_PAYLOAD) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/fifo_frame_reader_csum8.sv
// frame_csum8: 8-bit additive checksum, cleared at frame start, accumulated per accepted byte.
// Present only when FIFO_FRAME_READER_CSUM_EN is defined; sum_o is the registered running total.
`ifdef FIFO_FRAME_READER_CSUM_EN
module frame_csum8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_i,
    input  logic       acc_en_i,
    input  logic [7:0] din_i,
    output logic [7:0] sum_o
);

    logic [7:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (clr_i) begin
            sum_d = 8'h00;
        end else if (acc_en_i) begin
            sum_d = sum_q + din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q <= 8'h00;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;

endmodule
`endif

// File: rtl/fifo_frame_reader.sv
// Drains one FRAME_LEN payload from the byte FIFO as SYNC0 SYNC1 SEQ payload [CSUM when FIFO_FRAME_READER_CSUM_EN].
// Latency: first byte valid 1 cycle after start; header bytes 1 cycle, payload bytes 3 cycles (FETCH, CAPT, PAYLOAD).
// Backpressure: tx_valid/tx_ready; byte and tx_eof held while stalled, no FIFO read until the byte is accepted.
module fifo_frame_reader
    import fifo_frame_pkg::*;
#(
    parameter int               WBITS     = 8,
    parameter int               FRAME_LEN = 64,
    parameter logic [WBITS-1:0] SYNC0     = WBITS'(SYNC0_DEF),
    parameter logic [WBITS-1:0] SYNC1     = WBITS'(SYNC1_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WBITS-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic [15:0]      fifo_cnt,
    output logic             fifo_rd_en,
    output logic [WBITS-1:0] tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_sof,
    output logic             tx_eof,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam logic [15:0]       START_CNT = 16'(FRAME_LEN);
    localparam logic [PIDX_W-1:0] LAST_IDX  = PIDX_W'(FRAME_LEN - 1);

    state_t            state_q, state_d;
    logic [PIDX_W-1:0] idx_q, idx_d;
    logic [WBITS-1:0]  data_q, data_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;
    logic              start;
    logic              hs;
    logic              last_payload;

    assign start        = en && (fifo_cnt >= START_CNT);
    assign tx_valid     = is_tx_state(state_q);
    assign hs           = tx_valid && tx_ready;
    assign last_payload = (idx_q == LAST_IDX);
    assign fifo_rd_en   = (state_q == ST_FETCH) && !fifo_empty;
    assign tx_sof       = (state_q == ST_SYNC0);
    assign busy         = (state_q != ST_IDLE);
    assign frame_cnt    = frame_cnt_q;

`ifdef FIFO_FRAME_READER_CSUM_EN
    logic [7:0] csum;
    logic       csum_clr;
    logic       csum_acc;

    // SEQ and payload bytes are summed as they are accepted; sync bytes are not.
    assign csum_clr = (state_q == ST_IDLE) && start;
    assign csum_acc = hs && ((state_q == ST_SEQ) || (state_q == ST_PAYLOAD));

    frame_csum8 u_csum (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (csum_clr),
        .acc_en_i (csum_acc),
        .din_i    (data_q[7:0]),
        .sum_o    (csum)
    );

    assign tx_data = (state_q == ST_CSUM) ? WBITS'(csum) : data_q;
    assign tx_eof  = (state_q == ST_CSUM);
`else
    assign tx_data = data_q;
    assign tx_eof  = (state_q == ST_PAYLOAD) && last_payload;
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        data_d  = data_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SYNC0;
                    idx_d   = '0;
                    data_d  = SYNC0;
                end
            end
            ST_SYNC0: begin
                if (hs) begin
                    state_d = ST_SYNC1;
                    data_d  = SYNC1;
                end
            end
            ST_SYNC1: begin
                // frame_cnt only moves on the tx_eof handshake, so this is its value at frame start.
                if (hs) begin
                    state_d = ST_SEQ;
                    data_d  = WBITS'(frame_cnt_q[7:0]);
                end
            end
            ST_SEQ: begin
                if (hs) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!fifo_empty) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                data_d  = fifo_dout;
                state_d = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (hs) begin
                    if (last_payload) begin
`ifdef FIFO_FRAME_READER_CSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_IDLE;
`endif
                    end else begin
                        state_d = ST_FETCH;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
`ifdef FIFO_FRAME_READER_CSUM_EN
            ST_CSUM: begin
                if (hs) begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign frame_cnt_d = frame_cnt_q + 16'(hs && tx_eof);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            data_q      <= '0;
            frame_cnt_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            data_q      <= data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Bench for fifo_frame_reader: behavioural FIFO, random backpressure/payload, frame-level scoreboard.
module tb_fifo_frame_reader;

    localparam int FL = 64;
`ifdef FIFO_FRAME_READER_CSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif
    localparam int LASTPOS   = FL + 2 + CS;
    localparam int FRAME_CYC = 2 + 3 * FL + CS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        fifo_empty = 1'b1;
    logic        tx_ready = 1'b0;
    logic [7:0]  fifo_dout = 8'h00;
    logic [15:0] fifo_cnt = 16'h0000;
    logic        fifo_rd_en, tx_valid, tx_sof, tx_eof, busy;
    logic [7:0]  tx_data;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    fifo_frame_reader #(.WBITS(8), .FRAME_LEN(FL)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_cnt   (fifo_cnt),
        .fifo_rd_en (fifo_rd_en),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_sof     (tx_sof),
        .tx_eof     (tx_eof),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Stimulus requests, applied at the next falling edge.
    logic rst_nxt = 1'b1, en_nxt = 1'b0, fe_nxt = 1'b0, fe_force = 1'b0, rnd_ready = 1'b0;
    logic [7:0] fq[$];
    logic [7:0] ref_q[$];
    logic rd_pend = 1'b0;
    int   cyc = 0;

    // Frame-level reference model.
    int         m_pos = 0, m_frames = 0;
    logic [7:0] m_sum = 8'h00;
    int         reads_in_frame = 0, sof_cyc = 0, last_eof_cyc = -1, seen = 0;
    logic       frame_clean = 1'b0, gap_chk = 1'b0, fc_pend = 1'b0, stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00, first_payload = 8'h00;
    logic       prev_eof = 1'b0;

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        ref_q.push_back(b);
    endtask

    task automatic score();
        logic [7:0] e;
        e = 8'h00;
        if (m_pos == 0) e = 8'hA5;
        else if (m_pos == 1) e = 8'h5A;
        else if (m_pos == 2) e = m_frames[7:0];
        else if (m_pos <= FL + 2) begin
            if (ref_q.size() > 0) e = ref_q.pop_front();
        end else e = m_sum;
        check_eq("tx_data", 32'(tx_data), 32'(e));
        check_eq("tx_sof", 32'(tx_sof), 32'(m_pos == 0));
        check_eq("tx_eof", 32'(tx_eof), 32'(m_pos == LASTPOS));
        if (m_pos == 3) first_payload = tx_data;
        if (m_pos >= 2 && m_pos <= FL + 2) m_sum += e;
        if (m_pos == 0) begin
            if (gap_chk && last_eof_cyc >= 0) check_eq("frame_gap", 32'(cyc - last_eof_cyc), 32'd2);
            sof_cyc     = cyc;
            frame_clean = 1'b1;
        end
        if (m_pos == LASTPOS) begin
            check_eq("rd_pulses", 32'(reads_in_frame), 32'(FL));
            if (frame_clean) check_eq("frame_len_cyc", 32'(cyc - sof_cyc), 32'(FRAME_CYC));
            last_eof_cyc   = cyc;
            m_frames++;
            m_pos          = 0;
            m_sum          = 8'h00;
            reads_in_frame = 0;
            fc_pend        = 1'b1;
        end else begin
            m_pos++;
        end
    endtask

    task automatic monitor();
        if (rst) begin
            m_pos = 0; m_frames = 0; m_sum = 8'h00; reads_in_frame = 0;
            stall_prev = 1'b0; fc_pend = 1'b0; last_eof_cyc = -1;
            if (fifo_rd_en) rd_pend = 1'b1;
            return;
        end
        if (fc_pend) begin
            check_eq("frame_cnt", 32'(frame_cnt), 32'(m_frames[15:0]));
            fc_pend = 1'b0;
        end
        if (stall_prev) begin
            check_eq("hold_valid", 32'(tx_valid), 32'd1);
            check_eq("hold_data", 32'(tx_data), 32'(prev_data));
            check_eq("hold_eof", 32'(tx_eof), 32'(prev_eof));
        end
        stall_prev = tx_valid && !tx_ready;
        prev_data  = tx_data;
        prev_eof   = tx_eof;
        if (fifo_empty) check_eq("rd_when_empty", 32'(fifo_rd_en), 32'd0);
        if (fifo_rd_en) begin
            rd_pend = 1'b1;
            reads_in_frame++;
        end
        if (rnd_ready || fe_force) frame_clean = 1'b0;
        if (tx_valid && tx_ready) score();
        if (tx_valid || fifo_rd_en) seen++;
    endtask

    task automatic cycle();
        @(negedge clk);
        cyc++;
        fifo_dout = 8'h00;
        if (rd_pend) begin
            if (fq.size() > 0) fifo_dout = fq.pop_front();
            rd_pend = 1'b0;
        end
        rst      = rst_nxt;
        en       = en_nxt;
        fe_force = fe_nxt;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        fifo_cnt   = 16'(fq.size());
        fifo_empty = fe_force || (fq.size() == 0);
        #1;
        monitor();
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && m_frames < n; i++) cycle();
        if (m_frames < n) check_eq("timeout_frames", 32'(m_frames), 32'(n));
    endtask

    task automatic wait_pos(input int p, input int budget);
        for (int i = 0; i < budget && m_pos != p; i++) cycle();
        if (m_pos != p) check_eq("timeout_pos", 32'(m_pos), 32'(p));
    endtask

    initial begin
        repeat (3) cycle();
        check_eq("rst_state", 32'({tx_valid, tx_sof, tx_eof, busy, fifo_rd_en, tx_data, frame_cnt}), 32'd0);
        rst_nxt = 1'b0;
        cycle();

        // Preloaded ramp, ready held high.
        for (int i = 0; i < 64; i++) push(8'(i));
        en_nxt = 1'b1;
        cycle();
        check_eq("start_lat_idle", 32'(tx_valid), 32'd0);
        cycle();
        check_eq("start_lat_sof", 32'({tx_valid, tx_sof, tx_data}), 32'({2'b11, 8'hA5}));
        wait_frames(1, 400);
        cycle();
        check_eq("frame_cnt_1", 32'(frame_cnt), 32'd1);

        // One byte short of a frame, then the last byte arrives; random backpressure.
        for (int i = 0; i < 63; i++) push(8'(8'h40 + i));
        seen = 0;
        repeat (10) cycle();
        check_eq("below_thr_activity", 32'(seen), 32'd0);
        push(8'h7F);
        for (int i = 0; i < 2 && tx_valid !== 1'b1; i++) cycle();
        check_eq("thr_start", 32'(tx_valid), 32'd1);
        rnd_ready = 1'b1;
        wait_frames(2, 2000);
        rnd_ready = 1'b0;

        // Fresh reset, two back-to-back frames.
        en_nxt  = 1'b0;
        rst_nxt = 1'b1;
        cycle(); cycle();
        rst_nxt = 1'b0;
        for (int i = 0; i < 128; i++) push(8'(i * 3 + 1));
        gap_chk = 1'b1;
        en_nxt  = 1'b1;
        wait_frames(2, 800);
        gap_chk = 1'b0;
        cycle();
        check_eq("frame_cnt_2", 32'(frame_cnt), 32'd2);

        // Random payload, en dropped mid-frame, FIFO empty forced during a fetch.
        for (int i = 0; i < 64; i++) push(8'($urandom));
        wait_pos(2, 50);
        en_nxt = 1'b0;
        wait_pos(8, 100);
        fe_nxt = 1'b1;
        repeat (8) cycle();
        check_eq("empty_hold_pos", 32'(m_pos), 32'd8);
        check_eq("empty_hold_state", 32'({busy, tx_valid, fifo_rd_en}), 32'(3'b100));
        fe_nxt = 1'b0;
        wait_frames(3, 800);

        // Reset while payload byte 10 is being fetched; the frame restarts from the FIFO head.
        en_nxt = 1'b1;
        for (int i = 0; i < 64; i++) push(8'(8'hC0 + i));
        wait_pos(13, 200);
        fe_nxt = 1'b1;
        cycle(); cycle();
        rst_nxt = 1'b1;
        cycle(); cycle();
        check_eq("rst_mid_outputs", 32'({tx_valid, tx_sof, tx_eof, busy, fifo_rd_en, tx_data, frame_cnt}), 32'd0);
        rst_nxt = 1'b0;
        fe_nxt  = 1'b0;
        ref_q   = fq;
        for (int i = 0; i < 10; i++) push(8'(8'h20 + i));
        wait_frames(1, 800);
        check_eq("rst_resume_first", 32'(first_payload), 32'h0000_00CA);
        en_nxt = 1'b0;
        repeat (3) cycle();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
